// File: rtl/sigmul_round_if.sv
// Handshake bus for the significand multiply round stage: an upstream
// product channel and a downstream rounded-result channel.
interface sigmul_round_if #(
   parameter int NSIG = 10,
   parameter int NEXP = 5
);

   // Upstream product channel
   logic                  in_valid;
   logic                  in_ready;
   logic [2*NSIG+1:0]     in_p;
   logic [NEXP+1:0]       in_exp;
   logic                  in_sign;

   // Downstream result channel
   logic                  out_valid;
   logic                  out_ready;
   logic [NSIG:0]         out_sig;
   logic [NEXP+1:0]       out_exp;
   logic                  out_sign;
   logic                  out_inexact;

   // Producer of products and consumer of results (testbench / neighbours)
   modport master (
      output in_valid, in_p, in_exp, in_sign, out_ready,
      input  in_ready, out_valid, out_sig, out_exp, out_sign, out_inexact
   );

   // The rounding block itself
   modport slave (
      input  in_valid, in_p, in_exp, in_sign, out_ready,
      output in_ready, out_valid, out_sig, out_exp, out_sign, out_inexact
   );

endinterface

// File: rtl/sigmul_round.sv
// Two-stage normalize/round pipeline for a floating-point significand
// product. S1 normalizes the 2*NSIG+2 bit product to NSIG+1 bits and
// extracts guard/sticky; S2 rounds to nearest-even and fixes the exponent
// on a rounding carry. Each stage has its own valid bit and the pipeline
// stalls backwards from out_ready with no bubbles at full throughput.
module sigmul_round #(
   parameter int NSIG = 10,
   parameter int NEXP = 5
) (
   input  logic           clk,
   input  logic           rst,
   sigmul_round_if.slave  bus
);

   localparam int SW = NSIG + 1;       // significand width incl. hidden bit
   localparam int EW = NEXP + 2;       // exponent width
   localparam int PW = 2 * NSIG + 2;   // product width

   // ---------------------------------------------------------------
   // Stage registers
   // ---------------------------------------------------------------
   logic          r_s1_valid;
   logic [SW-1:0] r_s1_sig;
   logic          r_s1_guard;
   logic          r_s1_sticky;
   logic [EW-1:0] r_s1_exp;
   logic          r_s1_sign;

   logic          r_s2_valid;
   logic [SW-1:0] r_s2_sig;
   logic [EW-1:0] r_s2_exp;
   logic          r_s2_sign;
   logic          r_s2_inexact;

   // ---------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------
   logic w_s2_load;
   logic w_s1_load;

   // S2 drains when empty or the consumer takes the result; S1 can refill
   // whenever its content moves on (or it is empty).
   assign w_s2_load = ~r_s2_valid | bus.out_ready;
   assign w_s1_load = ~r_s1_valid | w_s2_load;

   // No input transfer is reported while the block is being reset.
   assign bus.in_ready = w_s1_load & ~rst;

   // ---------------------------------------------------------------
   // S1 normalize (combinational front end)
   // ---------------------------------------------------------------
   logic [SW-1:0] w_n_sig;
   logic          w_n_guard;
   logic          w_n_sticky;
   logic [EW-1:0] w_n_exp;

   // Select the significand window: a product >= 2.0 shifts right by one
   // and bumps the exponent; otherwise the window is taken as-is.
   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      w_n_sig    = bus.in_p[2*NSIG:NSIG];
      w_n_guard  = bus.in_p[NSIG-1];
      w_n_sticky = |bus.in_p[NSIG-2:0];
      w_n_exp    = bus.in_exp;
      if (bus.in_p[PW-1]) begin
         w_n_sig    = bus.in_p[PW-1:NSIG+1];
         w_n_guard  = bus.in_p[NSIG];
         w_n_sticky = |bus.in_p[NSIG-1:0];
         w_n_exp    = bus.in_exp + EW'(1);
      end
   end

   // S1 register: capture the normalized product on an input transfer.
   // NOTE: S1 data carries no reset; its valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_load) begin
         // NOTE: sequential state uses non-blocking assignments only.
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_sig    <= w_n_sig;
            r_s1_guard  <= w_n_guard;
            r_s1_sticky <= w_n_sticky;
            r_s1_exp    <= w_n_exp;
            r_s1_sign   <= bus.in_sign;
         end
      end
   end

   // ---------------------------------------------------------------
   // S2 round (combinational from S1 registers)
   // ---------------------------------------------------------------
   logic          w_round_up;
   logic [SW:0]   w_sum;
   logic [SW-1:0] w_r_sig;
   logic [EW-1:0] w_r_exp;

   assign w_round_up = r_s1_guard & (r_s1_sticky | r_s1_sig[0]);
   assign w_sum      = {1'b0, r_s1_sig} + (SW+1)'(w_round_up);

   // Round to nearest, ties to even; a carry out of an all-ones
   // significand renormalizes to 1.000... with exponent + 1.
   always_comb begin
      w_r_sig = w_sum[SW-1:0];
      w_r_exp = r_s1_exp;
      if (w_sum[SW]) begin
         w_r_sig = {1'b1, {NSIG{1'b0}}};
         w_r_exp = r_s1_exp + EW'(1);
      end
   end

   // S2 register: result is held here and drives the outputs directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid   <= 1'b0;
         r_s2_sig     <= '0;
         r_s2_exp     <= '0;
         r_s2_sign    <= 1'b0;
         r_s2_inexact <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sig     <= w_r_sig;
            r_s2_exp     <= w_r_exp;
            r_s2_sign    <= r_s1_sign;
            r_s2_inexact <= r_s1_guard | r_s1_sticky;
         end
      end
   end

   assign bus.out_valid   = r_s2_valid;
   assign bus.out_sig     = r_s2_sig;
   assign bus.out_exp     = r_s2_exp;
   assign bus.out_sign    = r_s2_sign;
   assign bus.out_inexact = r_s2_inexact;

endmodule

// File: tb/tb_sigmul_round.sv
// Self-checking bench for sigmul_round: directed vectors with known
// results, a randomly back-pressured stream checked against an
// independent rounding model, and reset during a full stall.
module tb_sigmul_round;

   localparam int NSIG = 10;
   localparam int NEXP = 5;

   typedef struct packed {
      logic [NSIG:0]   sig;
      logic [NEXP+1:0] exp;
      logic            sign;
      logic            inx;
   } res_t;

   logic clk = 1'b0;
   logic rst;

   sigmul_round_if #(.NSIG(NSIG), .NEXP(NEXP)) bus ();

   sigmul_round #(.NSIG(NSIG), .NEXP(NEXP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_in    = 0;
   int   n_out   = 0;
   res_t sb_q[$];
   res_t t_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference rounding written as integer arithmetic on the whole product.
   function automatic res_t model(input logic [2*NSIG+1:0] p, input logic [NEXP+1:0] e,
                                  input logic s);
      res_t            r;
      int              sh;
      longint unsigned sig, rem, half;
      sh    = p[2*NSIG+1] ? NSIG + 1 : NSIG;
      r.exp = e + (NEXP+2)'(p[2*NSIG+1]);
      sig   = 64'(p) >> sh;
      rem   = 64'(p) - (sig << sh);
      half  = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && sig[0])) sig++;
      if (sig == (64'd1 << (NSIG + 1))) begin
         sig   = 64'd1 << NSIG;
         r.exp = r.exp + (NEXP+2)'(1);
      end
      r.sig  = (NSIG+1)'(sig);
      r.sign = s;
      r.inx  = (rem != 0);
      return r;
   endfunction

   // Scoreboard monitor, sampled on the falling edge while signals are stable.
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready_vs_occupancy", 32'(bus.in_ready),
               32'(!(sb_q.size() == 2 && !bus.out_ready)));
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               check("output_without_input", 32'(sb_q.size()), 32'd1);
            end else begin
               res_t e;
               e = sb_q.pop_front();
               check("result", 32'({bus.out_sig, bus.out_exp, bus.out_sign, bus.out_inexact}),
                     32'(e));
               n_out++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(t_exp);
            n_in++;
         end
      end
   end

   // Present one product until it is accepted; optionally randomize out_ready.
   task automatic send(input logic [2*NSIG+1:0] p, input logic [NEXP+1:0] e, input logic s,
                       input res_t expv, input bit rnd_ready);
      bit accepted;
      int n;
      accepted     = 1'b0;
      n            = 0;
      bus.in_valid = 1'b1;
      bus.in_p     = p;
      bus.in_exp   = e;
      bus.in_sign  = s;
      t_exp        = expv;
      while (!accepted && n < 50) begin
         if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         accepted = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!accepted) check("accept_timeout", 32'(n), 32'd0);
      bus.in_valid = 1'b0;
   endtask

   function automatic res_t mk(input logic [NSIG:0] sg, input logic [NEXP+1:0] ex,
                               input logic sn, input logic ix);
      res_t r;
      r.sig = sg; r.exp = ex; r.sign = sn; r.inx = ix;
      return r;
   endfunction

   initial begin
      logic [2*NSIG+1:0] rp;
      logic [NEXP+1:0]   re;
      logic              rs;
      int                w;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_p      = '0;
      bus.in_exp    = '0;
      bus.in_sign   = 1'b0;
      bus.out_ready = 1'b0;
      t_exp         = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",    32'(bus.in_ready),    32'd0);
      check("rst_out_valid",   32'(bus.out_valid),   32'd0);
      check("rst_out_sig",     32'(bus.out_sig),     32'd0);
      check("rst_out_exp",     32'(bus.out_exp),     32'd0);
      check("rst_out_sign",    32'(bus.out_sign),    32'd0);
      check("rst_out_inexact", 32'(bus.out_inexact), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Exact 1.0 product and two-cycle latency
      bus.out_ready = 1'b1;
      send(22'h100000, 7'd15, 1'b0, mk(11'h400, 7'd15, 1'b0, 1'b0), 1'b0);
      check("latency_cycle1", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("latency_cycle2", 32'(bus.out_valid), 32'd1);

      // Directed rounding cases
      send(22'h3FF001, 7'd15, 1'b1, mk(11'h7FE, 7'd16, 1'b1, 1'b1), 1'b0);
      send(22'h1FFE00, 7'd15, 1'b0, mk(11'h400, 7'd16, 1'b0, 1'b1), 1'b0);
      send(22'h100200, 7'd15, 1'b0, mk(11'h400, 7'd15, 1'b0, 1'b1), 1'b0);
      send(22'h100600, 7'd15, 1'b1, mk(11'h402, 7'd15, 1'b1, 1'b1), 1'b0);
      send(22'h000000, 7'd9,  1'b0, mk(11'h000, 7'd9,  1'b0, 1'b0), 1'b0);
      send(22'h200000, 7'd127, 1'b0, mk(11'h400, 7'd0, 1'b0, 1'b0), 1'b0);
      repeat (4) @(posedge clk);
      #1;

      // Back-to-back stream with random back-pressure
      for (int i = 0; i < 8; i++) begin
         rp = 22'($urandom);
         re = 7'($urandom_range(0, 127));
         rs = 1'($urandom_range(0, 1));
         send(rp, re, rs, model(rp, re, rs), 1'b1);
      end
      bus.out_ready = 1'b1;
      w = 0;
      while (sb_q.size() != 0 && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("stream_drained", 32'(sb_q.size()), 32'd0);

      // Fill both stages with the consumer stalled, then reset
      bus.out_ready = 1'b0;
      send(22'h180000, 7'd20, 1'b0, model(22'h180000, 7'd20, 1'b0), 1'b0);
      send(22'h2AAAAA, 7'd20, 1'b1, model(22'h2AAAAA, 7'd20, 1'b1), 1'b0);
      @(negedge clk);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready",  32'(bus.in_ready),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      sb_q.delete();
      #1;
      check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid_out_sig",   32'(bus.out_sig),   32'd0);
      check("rst_mid_in_ready1", 32'(bus.in_ready),  32'd1);
      bus.out_ready = 1'b1;
      send(22'h100600, 7'd3, 1'b0, mk(11'h402, 7'd3, 1'b0, 1'b1), 1'b0);
      w = 0;
      while (sb_q.size() != 0 && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("final_drained", 32'(sb_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("final_out_valid", 32'(bus.out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sigmul_round.md
SIGMUL_ROUND -- requirements
Module: sigmul_round

Interface
REQ-001 SHALL have parameter NSIG, default 10, giving the stored significand width; the product input is 2*NSIG+2 bits.
REQ-002 SHALL have parameter NEXP, default 5, giving the exponent field width; exponent ports are NEXP+2 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream product is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the input this cycle.
REQ-007 SHALL have port in_p, input, 2*NSIG+2, the unsigned significand product with binary point between bits 2*NSIG and 2*NSIG-1.
REQ-008 SHALL have port in_exp, input, NEXP+2, the unsigned biased exponent sum.
REQ-009 SHALL have port in_sign, input, 1, the product sign.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-012 SHALL have port out_sig, output, NSIG+1, the rounded significand including the hidden bit.
REQ-013 SHALL have port out_exp, output, NEXP+2, the adjusted exponent.
REQ-014 SHALL have port out_sign, output, 1, in_sign passed through.
REQ-015 SHALL have port out_inexact, output, 1, set when any discarded bit was 1.

Function
REQ-016 SHALL transfer an input on a clk edge where in_valid and in_ready are both 1, and an output where out_valid and out_ready are both 1.
REQ-017 SHALL be a two-stage pipeline: S1 normalize, S2 round; each stage has a valid bit; latency from input transfer to out_valid is 2 cycles when not stalled.
REQ-018 S2 SHALL load when S2 is empty or out_ready=1; S1 SHALL load when S1 is empty or S2 loads; in_ready SHALL equal the S1 load condition (combinational from out_ready permitted).
REQ-019 Throughput SHALL be one result per cycle with out_ready held at 1; no transaction SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-020 A stalled stage SHALL hold its data and valid unchanged.
REQ-021 S1, if in_p[2*NSIG+1]=1: sig=in_p[2*NSIG+1:NSIG+1], guard=in_p[NSIG], sticky=OR(in_p[NSIG-1:0]), exp=in_exp+1.
REQ-022 S1, otherwise: sig=in_p[2*NSIG:NSIG], guard=in_p[NSIG-1], sticky=OR(in_p[NSIG-2:0]), exp=in_exp; no left shift is performed when in_p[2*NSIG]=0 as well.
REQ-023 S2 SHALL round to nearest, ties to even: increment sig when guard & (sticky | sig[0]).
REQ-024 If the increment carries out of sig (sig all ones), out_sig SHALL be 1 followed by NSIG zeros and out_exp SHALL be exp+1.
REQ-025 out_inexact SHALL equal guard | sticky.
REQ-026 Exponent arithmetic SHALL be modulo 2^(NEXP+2); overflow detection is out of scope.
REQ-027 in_p=0 SHALL yield out_sig=0, out_exp=in_exp, out_inexact=0.
REQ-028 Output ports SHALL be driven directly from S2 registers.

Reset
REQ-029 While rst=1 at a clk edge, both stage valids, out_sig, out_exp, out_sign and out_inexact SHALL become 0; in-flight data is discarded.
REQ-030 During a cycle with rst=1, the block SHALL not report an input transfer; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset mid-stall SHALL clear out_valid regardless of out_ready.

Verification
REQ-032 in_p=0x100000, in_exp=15, NSIG=10, out_ready=1 -> 2 cycles later out_sig=0x400, out_exp=15, out_inexact=0.
REQ-033 in_p=0x3FF001 (0x7FF*0x7FF), in_exp=15 -> out_sig=0x7FE, out_exp=16, out_inexact=1.
REQ-034 in_p=0x1FFE00, in_exp=15 -> round carry: out_sig=0x400, out_exp=16, out_inexact=1.
REQ-035 in_p=0x100200 (exact tie, even LSB) -> out_sig=0x400, out_exp=15, out_inexact=1; in_p=0x100600 -> out_sig=0x402.
REQ-036 Stream 8 back-to-back inputs with out_ready toggling randomly -> all 8 results in order, none lost or duplicated, in_ready=0 exactly when both stages are full and out_ready=0.
REQ-037 Assert rst for one cycle with both stages full and out_ready=0 -> out_valid=0 next cycle, the next accepted input emerges with correct value.
